// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared widths and state type for the Cramer-rule quotient solver
package rt_pkg;
  localparam int DW_DEF = 99;
  localparam int F_DEF  = 16;
  localparam int QW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/div_lane.sv
// rtl/div_lane.sv - one unsigned restoring divider lane, one quotient bit per step
module div_lane #(
  parameter int DW = 99,
  parameter int N  = 115
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [N-1:0]  i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic [N-1:0]  o_quot
);
  logic [N-1:0]  quo_q;
  logic [DW-1:0] rem_q;
  logic [DW:0]   rem_sh;
  logic [DW-1:0] diff;
  logic          take;

  // Remainder stays below the divisor, so the low DW bits of the difference are exact.
  always_comb begin
    rem_sh = {rem_q, quo_q[N-1]};
    take   = (rem_sh >= {1'b0, i_divisor});
    diff   = rem_sh[DW-1:0] - i_divisor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
    end else if (i_load) begin
      quo_q <= i_dividend;
      rem_q <= '0;
    end else if (i_step) begin
      quo_q <= {quo_q[N-2:0], take};
      rem_q <= take ? diff : rem_sh[DW-1:0];
    end
  end

  assign o_quot = quo_q;
endmodule

// File: rtl/cramer_solve.sv
// rtl/cramer_solve.sv - three signed fixed-point quotients Dt/D, Du/D, Dv/D
module cramer_solve
  import rt_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int F  = F_DEF,
  parameter int QW = QW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_det,
  input  logic [DW-1:0] i_det_t,
  input  logic [DW-1:0] i_det_u,
  input  logic [DW-1:0] i_det_v,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [QW-1:0] o_t,
  output logic [QW-1:0] o_u,
  output logic [QW-1:0] o_v,
  output logic          o_degen,
  output logic          o_sat
);
  localparam int N  = DW + F;
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] POS_LIM = N'({1'b0, {(QW-1){1'b1}}});
  localparam logic [N-1:0] NEG_LIM = N'({1'b1, {(QW-1){1'b0}}});

  function automatic logic [DW-1:0] mag_of(input logic [DW-1:0] v);
    return v[DW-1] ? (~v + 1'b1) : v;
  endfunction

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] mag_d_q;
  logic          sgn_d_q;
  logic [2:0]    sgn_x_q;
  logic          o_valid_q, o_degen_q, o_sat_q;
  logic [QW-1:0] o_t_q, o_u_q, o_v_q;
  logic          accept, step;
  logic [DW-1:0] num [3];

  assign accept = (state_q == IDLE) && i_valid;
  assign step   = (state_q == DIV);
  assign num    = '{i_det_t, i_det_u, i_det_v};

  for (genvar g = 0; g < 3; g++) begin : g_lane
    logic [N-1:0]  quot;
    logic [QW-1:0] val;
    logic          sat;

    div_lane #(.DW(DW), .N(N)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (accept),
      .i_step     (step),
      .i_dividend ({mag_of(num[g]), {F{1'b0}}}),
      .i_divisor  (mag_d_q),
      .o_quot     (quot)
    );

    // Negative results may reach one more in magnitude than positive ones.
    always_comb begin
      sat = 1'b0;
      val = quot[QW-1:0];
      if (sgn_x_q[g] ^ sgn_d_q) begin
        if (quot > NEG_LIM) begin
          sat = 1'b1;
          val = {1'b1, {(QW-1){1'b0}}};
        end else begin
          val = -quot[QW-1:0];
        end
      end else if (quot > POS_LIM) begin
        sat = 1'b1;
        val = {1'b0, {(QW-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mag_d_q   <= '0;
      sgn_d_q   <= 1'b0;
      sgn_x_q   <= '0;
      o_valid_q <= 1'b0;
      o_degen_q <= 1'b0;
      o_sat_q   <= 1'b0;
      o_t_q     <= '0;
      o_u_q     <= '0;
      o_v_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          mag_d_q <= mag_of(i_det);
          sgn_d_q <= i_det[DW-1];
          sgn_x_q <= {i_det_v[DW-1], i_det_u[DW-1], i_det_t[DW-1]};
          cnt_q   <= CW'(N);
          if (i_det == '0) begin
            state_q   <= DONE;
            o_t_q     <= '0;
            o_u_q     <= '0;
            o_v_q     <= '0;
            o_degen_q <= 1'b1;
            o_sat_q   <= 1'b0;
          end else begin
            state_q <= DIV;
          end
        end
        DIV: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          o_t_q     <= g_lane[0].val;
          o_u_q     <= g_lane[1].val;
          o_v_q     <= g_lane[2].val;
          o_sat_q   <= g_lane[0].sat | g_lane[1].sat | g_lane[2].sat;
          o_degen_q <= 1'b0;
          state_q   <= DONE;
        end
        DONE: begin
          // Valid trails entry into DONE by one edge; handshake only once it is visible.
          if (!o_valid_q) begin
            o_valid_q <= 1'b1;
          end else if (o_ready) begin
            o_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_ready = (state_q == IDLE);
  assign o_valid = o_valid_q;
  assign o_t     = o_t_q;
  assign o_u     = o_u_q;
  assign o_v     = o_v_q;
  assign o_degen = o_degen_q;
  assign o_sat   = o_sat_q;
endmodule
